bp_be_ptw_walker: RTL and testbench

Hardware Sv39 page-table walker for the backend. When a TLB miss is reported, it walks the page table with 8-byte PTE reads through a simple memory request/response port. On success it produces a TLB fill; on failure it raises a one-cycle instruction, load or store page-fault pulse. The pulses feed the system pipe's `ptw_pkt` `*_page_fault_v` inputs, which turn them into CSR exception commands.

---
 rtl/bp_be_ptw_walker.sv | 220 ++++++++++++++++++++++
 tb/tb_bp_be_ptw_walker.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_ptw_walker.sv
// Sv39 hardware page-table walker.
// A TLB miss starts a walk from the root table (satp), issuing one 8-byte PTE
// read per level. A valid leaf becomes a one-cycle TLB fill; any malformed,
// misaligned or permission-failing PTE becomes a one-cycle page-fault pulse
// of the latched request type. Flush aborts the walk, and an outstanding
// response is swallowed in DRAIN so it cannot be mistaken for a later walk's.
module bp_be_ptw_walker #(
    parameter int vaddr_width_p = 39,
    parameter int paddr_width_p = 40,
    parameter int ppn_width_p   = 28
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [ppn_width_p-1:0]     satp_ppn_i,
    input  logic                       flush_i,
    input  logic                       miss_v_i,
    input  logic [1:0]                 miss_type_i,
    input  logic [vaddr_width_p-1:0]   miss_vaddr_i,
    output logic                       busy_o,
    output logic                       mem_req_v_o,
    output logic [paddr_width_p-1:0]   mem_req_paddr_o,
    input  logic                       mem_req_ready_i,
    input  logic                       mem_resp_v_i,
    input  logic [63:0]                mem_resp_data_i,
    output logic                       tlb_w_v_o,
    output logic [vaddr_width_p-13:0]  tlb_w_vtag_o,
    output logic [ppn_width_p-1:0]     tlb_w_ptag_o,
    output logic [7:0]                 tlb_w_flags_o,
    output logic                       instr_page_fault_v_o,
    output logic                       load_page_fault_v_o,
    output logic                       store_page_fault_v_o
);

    localparam int vtag_width_lp = vaddr_width_p - 12;

    localparam logic [1:0] TYPE_INSTR = 2'd0;
    localparam logic [1:0] TYPE_STORE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                   r_state, w_state_next;
    logic [vtag_width_lp-1:0] r_vtag,  w_vtag_next;
    logic [1:0]               r_type,  w_type_next;
    logic [1:0]               r_level, w_level_next;
    logic [ppn_width_p-1:0]   r_ppn,   w_ppn_next;
    logic                     r_fault, w_fault_next;
    logic [ppn_width_p-1:0]   r_ptag,  w_ptag_next;
    logic [7:0]               r_flags, w_flags_next;

    // Per-level VPN slices of the latched virtual address.
    logic [8:0] w_vpn [3];
    for (genvar gi = 0; gi < 3; gi++) begin : g_vpn
        assign w_vpn[gi] = r_vtag[9*gi +: 9];
    end

    // VPN slice that indexes the table at the current level.
    logic [8:0] w_vpn_sel;
    always_comb begin
        case (r_level)
            2'd2:    w_vpn_sel = w_vpn[2];
            2'd1:    w_vpn_sel = w_vpn[1];
            default: w_vpn_sel = w_vpn[0];
        endcase
    end

    // PTE field decode of the response data.
    logic [ppn_width_p-1:0] w_pte_ppn;
    logic w_pte_v, w_pte_r, w_pte_w, w_pte_x, w_pte_a, w_pte_d;
    logic w_leaf, w_misaligned, w_pte_fault;
    logic [ppn_width_p-1:0] w_fill_ptag;
    logic w_unused;

    assign w_pte_ppn = mem_resp_data_i[10 +: ppn_width_p];
    assign w_pte_v   = mem_resp_data_i[0];
    assign w_pte_r   = mem_resp_data_i[1];
    assign w_pte_w   = mem_resp_data_i[2];
    assign w_pte_x   = mem_resp_data_i[3];
    assign w_pte_a   = mem_resp_data_i[6];
    assign w_pte_d   = mem_resp_data_i[7];
    assign w_leaf    = w_pte_r | w_pte_x;
    assign w_unused  = ^{mem_resp_data_i[63:10+ppn_width_p], mem_resp_data_i[9:8],
                         miss_vaddr_i[11:0]};

    // Superpage leaves must have their low PPN bits clear; a filled
    // superpage is splintered by substituting the VPN bits it covers.
    always_comb begin
        w_misaligned = 1'b0;
        w_fill_ptag  = w_pte_ppn;
        case (r_level)
            2'd2: begin
                w_misaligned       = |w_pte_ppn[17:0];
                w_fill_ptag[17:9]  = w_vpn[1];
                w_fill_ptag[8:0]   = w_vpn[0];
            end
            2'd1: begin
                w_misaligned       = |w_pte_ppn[8:0];
                w_fill_ptag[8:0]   = w_vpn[0];
            end
            default: ;
        endcase
    end

    // A/D are never set by hardware, so a missing A (or D on store) faults.
    assign w_pte_fault = ~w_pte_v
                       | (~w_pte_r & w_pte_w)
                       | (w_leaf & (w_misaligned | ~w_pte_a
                                    | ((r_type == TYPE_STORE) & ~w_pte_d)))
                       | (~w_leaf & (r_level == 2'd0));

    // Next-state and datapath update logic.
    always_comb begin
        w_state_next = r_state;
        w_vtag_next  = r_vtag;
        w_type_next  = r_type;
        w_level_next = r_level;
        w_ppn_next   = r_ppn;
        w_fault_next = r_fault;
        w_ptag_next  = r_ptag;
        w_flags_next = r_flags;
        case (r_state)
            S_IDLE: begin
                if (miss_v_i && !flush_i) begin
                    w_state_next = S_SEND;
                    w_vtag_next  = miss_vaddr_i[vaddr_width_p-1:12];
                    w_type_next  = miss_type_i;
                    w_level_next = 2'd2;
                    w_ppn_next   = satp_ppn_i;
                    w_fault_next = 1'b0;
                end
            end
            S_SEND: begin
                // A request accepted alongside a flush still owes a response.
                if (flush_i) begin
                    w_state_next = mem_req_ready_i ? S_DRAIN : S_IDLE;
                end else if (mem_req_ready_i) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_v_i) begin
                    if (flush_i) begin
                        // Response already consumed this cycle: nothing to drain.
                        w_state_next = S_IDLE;
                    end else if (w_pte_fault) begin
                        w_state_next = S_DONE;
                        w_fault_next = 1'b1;
                        w_flags_next = mem_resp_data_i[7:0];
                    end else if (w_leaf) begin
                        w_state_next = S_DONE;
                        w_fault_next = 1'b0;
                        w_ptag_next  = w_fill_ptag;
                        w_flags_next = mem_resp_data_i[7:0];
                    end else begin
                        w_state_next = S_SEND;
                        w_ppn_next   = w_pte_ppn;
                        w_level_next = r_level - 2'd1;
                    end
                end else if (flush_i) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_resp_v_i) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_vtag  <= '0;
            r_type  <= '0;
            r_level <= '0;
            r_ppn   <= '0;
            r_fault <= 1'b0;
            r_ptag  <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_next;
            r_vtag  <= w_vtag_next;
            r_type  <= w_type_next;
            r_level <= w_level_next;
            r_ppn   <= w_ppn_next;
            r_fault <= w_fault_next;
            r_ptag  <= w_ptag_next;
            r_flags <= w_flags_next;
        end
    end

    logic w_done_fire;
    assign w_done_fire = (r_state == S_DONE) & ~flush_i;

    assign busy_o               = (r_state != S_IDLE);
    assign mem_req_v_o          = (r_state == S_SEND);
    assign mem_req_paddr_o      = {r_ppn, w_vpn_sel, 3'b000};
    assign tlb_w_v_o            = w_done_fire & ~r_fault;
    assign tlb_w_vtag_o         = r_vtag;
    assign tlb_w_ptag_o         = r_ptag;
    assign tlb_w_flags_o        = r_flags;
    assign instr_page_fault_v_o = w_done_fire & r_fault & (r_type == TYPE_INSTR);
    assign store_page_fault_v_o = w_done_fire & r_fault & (r_type == TYPE_STORE);
    assign load_page_fault_v_o  = w_done_fire & r_fault & (r_type != TYPE_INSTR)
                                & (r_type != TYPE_STORE);

endmodule

// File: tb/tb_bp_be_ptw_walker.sv
// Testbench for bp_be_ptw_walker: a PTE memory responder, a scoreboard of
// expected requests and fill/fault events, and one task per scenario.
module tb_bp_be_ptw_walker;

    localparam int K_FILL  = 1;
    localparam int K_INSTR = 2;
    localparam int K_LOAD  = 3;
    localparam int K_STORE = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [27:0] satp_ppn_i;
    logic        flush_i;
    logic        miss_v_i;
    logic [1:0]  miss_type_i;
    logic [38:0] miss_vaddr_i;
    logic        busy_o;
    logic        mem_req_v_o;
    logic [39:0] mem_req_paddr_o;
    logic        mem_req_ready_i;
    logic        mem_resp_v_i;
    logic [63:0] mem_resp_data_i;
    logic        tlb_w_v_o;
    logic [26:0] tlb_w_vtag_o;
    logic [27:0] tlb_w_ptag_o;
    logic [7:0]  tlb_w_flags_o;
    logic        instr_page_fault_v_o;
    logic        load_page_fault_v_o;
    logic        store_page_fault_v_o;

    bp_be_ptw_walker dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .satp_ppn_i           (satp_ppn_i),
        .flush_i              (flush_i),
        .miss_v_i             (miss_v_i),
        .miss_type_i          (miss_type_i),
        .miss_vaddr_i         (miss_vaddr_i),
        .busy_o               (busy_o),
        .mem_req_v_o          (mem_req_v_o),
        .mem_req_paddr_o      (mem_req_paddr_o),
        .mem_req_ready_i      (mem_req_ready_i),
        .mem_resp_v_i         (mem_resp_v_i),
        .mem_resp_data_i      (mem_resp_data_i),
        .tlb_w_v_o            (tlb_w_v_o),
        .tlb_w_vtag_o         (tlb_w_vtag_o),
        .tlb_w_ptag_o         (tlb_w_ptag_o),
        .tlb_w_flags_o        (tlb_w_flags_o),
        .instr_page_fault_v_o (instr_page_fault_v_o),
        .load_page_fault_v_o  (load_page_fault_v_o),
        .store_page_fault_v_o (store_page_fault_v_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          kind;
        logic [26:0] vtag;
        logic [27:0] ptag;
        logic [7:0]  flags;
    } ev_t;

    ev_t         exp_ev_q[$];
    logic [39:0] exp_req_q[$];
    logic [63:0] pte_q[$];

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int resp_delay  = 0;
    int last_ev_cyc = -1;

    localparam logic [38:0] VA = 39'h40201000;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory responder: checks each accepted request address against the
    // scoreboard and returns the next queued PTE resp_delay cycles later.
    initial begin
        logic [39:0] ex;
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_req_v_o && mem_req_ready_i) begin
                checks++;
                if (exp_req_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected: paddr %h, required no request", mem_req_paddr_o);
                end else begin
                    ex = exp_req_q.pop_front();
                    if (mem_req_paddr_o !== ex) begin
                        errors++;
                        $display("FAIL req_paddr: got %h, required %h", mem_req_paddr_o, ex);
                    end
                end
                @(posedge clk_i); #1;
                repeat (resp_delay) begin @(posedge clk_i); #1; end
                mem_resp_v_i    = 1'b1;
                mem_resp_data_i = (pte_q.size() != 0) ? pte_q.pop_front() : 64'h0;
                @(posedge clk_i); #1;
                mem_resp_v_i    = 1'b0;
            end
        end
    end

    // Event monitor: every fill/fault pulse is matched against the scoreboard.
    initial begin
        int  n;
        int  kind;
        ev_t e;
        forever begin
            @(negedge clk_i);
            n = int'(tlb_w_v_o) + int'(instr_page_fault_v_o)
              + int'(load_page_fault_v_o) + int'(store_page_fault_v_o);
            if (n != 0) begin
                last_ev_cyc = cyc;
                kind = tlb_w_v_o ? K_FILL : instr_page_fault_v_o ? K_INSTR :
                       load_page_fault_v_o ? K_LOAD : K_STORE;
                checks++;
                if (n > 1) begin
                    errors++;
                    $display("FAIL pulse_exclusive: %0d pulses together, required 1", n);
                end
                checks++;
                if (exp_ev_q.size() == 0) begin
                    errors++;
                    $display("FAIL event_unexpected: kind %0d, required no event", kind);
                end else begin
                    e = exp_ev_q.pop_front();
                    if (kind !== e.kind) begin
                        errors++;
                        $display("FAIL event_kind: got %0d, required %0d", kind, e.kind);
                    end else if (kind == K_FILL) begin
                        checks++;
                        if ({tlb_w_vtag_o, tlb_w_ptag_o, tlb_w_flags_o} !== {e.vtag, e.ptag, e.flags}) begin
                            errors++;
                            $display("FAIL fill_fields: vtag %h ptag %h flags %h, required vtag %h ptag %h flags %h",
                                     tlb_w_vtag_o, tlb_w_ptag_o, tlb_w_flags_o, e.vtag, e.ptag, e.flags);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_miss(input logic [1:0] t, input logic [38:0] va, output int mc);
        miss_type_i  = t;
        miss_vaddr_i = va;
        miss_v_i     = 1'b1;
        mc           = cyc;
        @(posedge clk_i); #1;
        miss_v_i     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (k < 300) begin
            @(negedge clk_i);
            if (!busy_o) break;
            k++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy %b, required 0", name, busy_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        checks++;
        if ({busy_o, mem_req_v_o, tlb_w_v_o, instr_page_fault_v_o,
             load_page_fault_v_o, store_page_fault_v_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/req/fill/faults %b%b%b%b%b%b, required 000000",
                     busy_o, mem_req_v_o, tlb_w_v_o, instr_page_fault_v_o,
                     load_page_fault_v_o, store_page_fault_v_o);
        end
        checks++;
        if (mem_req_paddr_o !== 40'h0) begin
            errors++;
            $display("FAIL reset_paddr: got %h, required 0", mem_req_paddr_o);
        end
        checks++;
        if ({tlb_w_vtag_o, tlb_w_ptag_o, tlb_w_flags_o} !== 63'h0) begin
            errors++;
            $display("FAIL reset_fill_regs: vtag %h ptag %h flags %h, required 0",
                     tlb_w_vtag_o, tlb_w_ptag_o, tlb_w_flags_o);
        end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_store_4k();
        int mc;
        exp_req_q.push_back(40'h80000008);
        exp_req_q.push_back(40'h80001008);
        exp_req_q.push_back(40'h80002008);
        pte_q.push_back(64'h20000401);
        pte_q.push_back(64'h20000801);
        pte_q.push_back(64'h048D14C7);
        exp_ev_q.push_back(ev_t'{K_FILL, 27'h40201, 28'h12345, 8'hC7});
        do_miss(2'd2, VA, mc);
        wait_idle("store_4k");
        checks++;
        if (last_ev_cyc !== mc + 7) begin
            errors++;
            $display("FAIL store_4k_latency: fill at cycle %0d, required %0d", last_ev_cyc, mc + 7);
        end
    endtask

    task automatic test_back_to_back();
        int m1, m2;
        exp_req_q.push_back(40'h80000008);
        exp_req_q.push_back(40'h80001008);
        exp_req_q.push_back(40'h80002008);
        exp_req_q.push_back(40'h80000008);
        pte_q.push_back(64'h20000401);
        pte_q.push_back(64'h20000801);
        pte_q.push_back(64'h048D1447);
        pte_q.push_back((64'h40000 << 10) | 64'hCB);
        exp_ev_q.push_back(ev_t'{K_FILL, 27'h40201, 28'h12345, 8'h47});
        exp_ev_q.push_back(ev_t'{K_FILL, 27'h40201, 28'h40201, 8'hCB});
        do_miss(2'd1, VA, m1);
        repeat (7) @(posedge clk_i);
        #1;
        checks++;
        if (last_ev_cyc !== m1 + 7) begin
            errors++;
            $display("FAIL b2b_first_latency: fill at cycle %0d, required %0d", last_ev_cyc, m1 + 7);
        end
        do_miss(2'd0, VA, m2);
        wait_idle("b2b");
        checks++;
        if (last_ev_cyc !== m2 + 3) begin
            errors++;
            $display("FAIL b2b_giga_latency: fill at cycle %0d, required %0d", last_ev_cyc, m2 + 3);
        end
    endtask

    task automatic test_gigapage_misaligned();
        int mc;
        exp_req_q.push_back(40'h80000008);
        pte_q.push_back((64'h40001 << 10) | 64'hCB);
        exp_ev_q.push_back(ev_t'{K_INSTR, 27'h0, 28'h0, 8'h0});
        do_miss(2'd0, VA, mc);
        wait_idle("giga_misaligned");
    endtask

    task automatic test_store_dirty();
        int mc;
        exp_req_q.push_back(40'h80000008);
        exp_req_q.push_back(40'h80001008);
        exp_req_q.push_back(40'h80002008);
        pte_q.push_back(64'h20000401);
        pte_q.push_back(64'h20000801);
        pte_q.push_back(64'h048D1447);
        exp_ev_q.push_back(ev_t'{K_STORE, 27'h0, 28'h0, 8'h0});
        do_miss(2'd2, VA, mc);
        wait_idle("store_dirty");
    endtask

    task automatic test_invalid();
        int mc;
        // V=0 at level 1: two requests, load fault
        exp_req_q.push_back(40'h80000008);
        exp_req_q.push_back(40'h80001008);
        pte_q.push_back(64'h20000401);
        pte_q.push_back(64'h0);
        exp_ev_q.push_back(ev_t'{K_LOAD, 27'h0, 28'h0, 8'h0});
        do_miss(2'd1, VA, mc);
        wait_idle("invalid_v0");
        checks++;
        if (exp_req_q.size() != 0) begin
            errors++;
            $display("FAIL invalid_v0_reqs: %0d requests missing, required 0", exp_req_q.size());
        end
        // R=0, W=1 at level 2
        exp_req_q.push_back(40'h80000008);
        pte_q.push_back(64'h20000405);
        exp_ev_q.push_back(ev_t'{K_LOAD, 27'h0, 28'h0, 8'h0});
        do_miss(2'd1, VA, mc);
        wait_idle("invalid_wonly");
        // non-leaf at level 0
        exp_req_q.push_back(40'h80000008);
        exp_req_q.push_back(40'h80001008);
        exp_req_q.push_back(40'h80002008);
        pte_q.push_back(64'h20000401);
        pte_q.push_back(64'h20000801);
        pte_q.push_back(64'h20000C01);
        exp_ev_q.push_back(ev_t'{K_STORE, 27'h0, 28'h0, 8'h0});
        do_miss(2'd2, VA, mc);
        wait_idle("invalid_nonleaf0");
        // leaf with A=0
        exp_req_q.push_back(40'h80000008);
        exp_req_q.push_back(40'h80001008);
        exp_req_q.push_back(40'h80002008);
        pte_q.push_back(64'h20000401);
        pte_q.push_back(64'h20000801);
        pte_q.push_back(64'h048D148B);
        exp_ev_q.push_back(ev_t'{K_INSTR, 27'h0, 28'h0, 8'h0});
        do_miss(2'd0, VA, mc);
        wait_idle("invalid_a0");
    endtask

    task automatic test_flush_wait();
        int mc;
        resp_delay = 3;
        exp_req_q.push_back(40'h80000008);
        pte_q.push_back(64'h20000401);
        do_miss(2'd1, VA, mc);
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (busy_o !== 1'b1) begin
                errors++;
                $display("FAIL flush_drain_busy[%0d]: busy %b, required 1", i, busy_o);
            end
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain_done: busy %b, required 0", busy_o);
        end
        @(posedge clk_i); #1;
        resp_delay = 0;
        exp_req_q.push_back(40'h80000008);
        exp_req_q.push_back(40'h80001008);
        exp_req_q.push_back(40'h80002008);
        pte_q.push_back(64'h20000401);
        pte_q.push_back(64'h20000801);
        pte_q.push_back(64'h048D14C7);
        exp_ev_q.push_back(ev_t'{K_FILL, 27'h40201, 28'h12345, 8'hC7});
        do_miss(2'd2, VA, mc);
        wait_idle("flush_after");
    endtask

    task automatic test_backpressure();
        int mc;
        mem_req_ready_i = 1'b0;
        exp_req_q.push_back(40'h80000008);
        pte_q.push_back((64'h40000 << 10) | 64'hCB);
        exp_ev_q.push_back(ev_t'{K_FILL, 27'h40201, 28'h40201, 8'hCB});
        do_miss(2'd0, VA, mc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++;
            if (mem_req_v_o !== 1'b1 || mem_req_paddr_o !== 40'h80000008) begin
                errors++;
                $display("FAIL bp_hold[%0d]: req_v %b paddr %h, required 1 80000008",
                         i, mem_req_v_o, mem_req_paddr_o);
            end
            @(posedge clk_i); #1;
        end
        mem_req_ready_i = 1'b1;
        wait_idle("backpressure");
    endtask

    task automatic test_reset_in_wait();
        int mc;
        resp_delay = 5;
        exp_req_q.push_back(40'h80000008);
        pte_q.push_back(64'h20000401);
        do_miss(2'd1, VA, mc);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({busy_o, mem_req_v_o, tlb_w_v_o, instr_page_fault_v_o,
             load_page_fault_v_o, store_page_fault_v_o} !== 6'b0 || mem_req_paddr_o !== 40'h0) begin
            errors++;
            $display("FAIL rst_wait_outputs: ctrl %b%b%b%b%b%b paddr %h, required 000000 0",
                     busy_o, mem_req_v_o, tlb_w_v_o, instr_page_fault_v_o,
                     load_page_fault_v_o, store_page_fault_v_o, mem_req_paddr_o);
        end
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_stale: busy %b after stale response, required 0", busy_o);
        end
        @(posedge clk_i); #1;
        resp_delay = 0;
    endtask

    task automatic test_final();
        checks++;
        if (exp_req_q.size() != 0 || exp_ev_q.size() != 0 || pte_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: reqs %0d events %0d ptes %0d, required 0 0 0",
                     exp_req_q.size(), exp_ev_q.size(), pte_q.size());
        end
    endtask

    initial begin
        reset_i         = 1'b1;
        satp_ppn_i      = 28'h80000;
        flush_i         = 1'b0;
        miss_v_i        = 1'b0;
        miss_type_i     = 2'd0;
        miss_vaddr_i    = '0;
        mem_req_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        test_store_4k();
        test_back_to_back();
        test_gigapage_misaligned();
        test_store_dirty();
        test_invalid();
        test_flush_wait();
        test_backpressure();
        test_reset_in_wait();
        test_final();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
